acs_butterfly: RTL and testbench

//  Add-compare-select butterfly for the hard-decision Viterbi decoder; sits directly

---
 rtl/acs_butterfly.sv | 150 +++++++++++++++
 tb/tb_acs_butterfly.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/acs_butterfly.sv
// rtl/acs_butterfly.sv - Viterbi add-compare-select butterfly with init, saturation, normalisation and traceback step count
// Two predecessors (a, b) feed two successors (0, 1); survivors and decisions are registered.
module acs_butterfly #(
  parameter int PM_W      = 8,
  parameter int INIT_ZERO = 0,
  parameter int INIT_HIGH = 32,
  parameter int TB_DEPTH  = 35
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a0,
  input  logic [1:0]      bm_a1,
  input  logic [1:0]      bm_b0,
  input  logic [1:0]      bm_b1,
  input  logic            norm_en,
  output logic            out_valid,
  output logic [PM_W-1:0] pm_0,
  output logic [PM_W-1:0] pm_1,
  output logic            dec_0,
  output logic            dec_1,
  output logic            norm_flag,
  output logic            tb_ready
);

  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] NORM_Q  = {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [PM_W-1:0] INIT_HI = INIT_HIGH[PM_W-1:0];
  localparam logic [PM_W-1:0] INIT_S0 = (INIT_ZERO != 0) ? '0 : INIT_HI;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [PM_W-1:0]   pm0_q, pm0_d, pm1_q, pm1_d;
  logic              dec0_q, dec0_d, dec1_q, dec1_d;
  logic              ov_q, ov_d;
  logic              rdy_q, rdy_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  function automatic logic [PM_W-1:0] normalise(input logic [PM_W-1:0] v, input logic en);
    if (!en)          return v;
    if (v >= NORM_Q)  return v - NORM_Q;
    return '0;
  endfunction

  logic [PM_W-1:0] ca0, cb0, ca1, cb1;
  logic            sel0, sel1;
  logic [PM_W-1:0] surv0, surv1;

  assign ca0   = sat_add(pm_a, bm_a0);
  assign cb0   = sat_add(pm_b, bm_b0);
  assign ca1   = sat_add(pm_a, bm_a1);
  assign cb1   = sat_add(pm_b, bm_b1);
  // Strict compare: ties resolve to predecessor a.
  assign sel0  = (cb0 < ca0);
  assign sel1  = (cb1 < ca1);
  assign surv0 = normalise(sel0 ? cb0 : ca0, norm_en);
  assign surv1 = normalise(sel1 ? cb1 : ca1, norm_en);

  always_comb begin
    state_d = state_q;
    pm0_d   = pm0_q;
    pm1_d   = pm1_q;
    dec0_d  = dec0_q;
    dec1_d  = dec1_q;
    ov_d    = 1'b0;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          pm0_d   = INIT_S0;
          pm1_d   = INIT_HI;
          dec0_d  = 1'b0;
          dec1_d  = 1'b0;
          rdy_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (start) begin
          state_d = S_INIT;
          pm0_d   = INIT_S0;
          pm1_d   = INIT_HI;
          dec0_d  = 1'b0;
          dec1_d  = 1'b0;
          rdy_d   = 1'b0;
          cnt_d   = '0;
        end else if (in_valid) begin
          pm0_d  = surv0;
          pm1_d  = surv1;
          dec0_d = sel0;
          dec1_d = sel1;
          ov_d   = 1'b1;
          cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          rdy_d  = (cnt_d == CNT_MAX);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pm0_q   <= '0;
      pm1_q   <= '0;
      dec0_q  <= 1'b0;
      dec1_q  <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pm0_q   <= pm0_d;
      pm1_q   <= pm1_d;
      dec0_q  <= dec0_d;
      dec1_q  <= dec1_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign pm_0      = pm0_q;
  assign pm_1      = pm1_q;
  assign dec_0     = dec0_q;
  assign dec_1     = dec1_q;
  assign tb_ready  = rdy_q;
  assign norm_flag = pm0_q[PM_W-1] | pm1_q[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// tb/tb_acs_butterfly.sv - directed self-checking bench for acs_butterfly
module tb_acs_butterfly;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] pm_a, pm_b;
  logic [1:0] bm_a0, bm_a1, bm_b0, bm_b1;
  logic       norm_en;
  logic       out_valid;
  logic [7:0] pm_0, pm_1;
  logic       dec_0, dec_1, norm_flag, tb_ready;

  int n_tests = 0;
  int n_fail  = 0;

  acs_butterfly #(.PM_W(8), .INIT_ZERO(1), .INIT_HIGH(32), .TB_DEPTH(35)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .pm_a(pm_a), .pm_b(pm_b),
    .bm_a0(bm_a0), .bm_a1(bm_a1), .bm_b0(bm_b0), .bm_b1(bm_b1),
    .norm_en(norm_en), .out_valid(out_valid), .pm_0(pm_0), .pm_1(pm_1),
    .dec_0(dec_0), .dec_1(dec_1), .norm_flag(norm_flag), .tb_ready(tb_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int a, input int b,
                       input int a0, input int b0, input int a1, input int b1,
                       input logic ne);
    in_valid = v;
    pm_a  = 8'(a);  pm_b  = 8'(b);
    bm_a0 = 2'(a0); bm_b0 = 2'(b0);
    bm_a1 = 2'(a1); bm_b1 = 2'(b1);
    norm_en = ne;
  endtask

  task automatic check_out(input string tag, input int ov, input int p0, input int d0,
                           input int p1, input int d1);
    check({tag, ".out_valid"}, int'(out_valid), ov);
    check({tag, ".pm_0"},      int'(pm_0),      p0);
    check({tag, ".dec_0"},     int'(dec_0),     d0);
    check({tag, ".pm_1"},      int'(pm_1),      p1);
    check({tag, ".dec_1"},     int'(dec_1),     d1);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    cycle();
    start = 1'b0;
    in_valid = 1'b0;
    check_out({tag, ".init"}, 0, 0, 0, 32, 0);
    check({tag, ".init.tb_ready"}, int'(tb_ready), 0);
    cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check_out("reset", 0, 0, 0, 0, 0);
    check("reset.tb_ready", int'(tb_ready), 0);
    check("reset.norm_flag", int'(norm_flag), 0);

    drive(1'b1, 10, 7, 2, 0, 0, 2, 1'b0);
    cycle();
    check_out("idle_ignore", 0, 0, 0, 0, 0);

    in_valid = 1'b0;
    do_start("start1");

    // INIT cycle input is ignored; the following RUN step must be the first result
    drive(1'b1, 10, 7, 2, 0, 0, 2, 1'b0);
    cycle();
    check_out("basic", 1, 7, 1, 9, 1);
    in_valid = 1'b0;
    cycle();
    check_out("hold", 0, 7, 1, 9, 1);

    drive(1'b1, 5, 4, 1, 2, 0, 0, 1'b0);
    cycle();
    check_out("tie0", 1, 6, 0, 4, 1);

    drive(1'b1, 254, 255, 0, 0, 2, 2, 1'b0);
    cycle();
    check_out("sat", 1, 254, 0, 255, 0);
    check("sat.norm_flag", int'(norm_flag), 1);

    drive(1'b1, 100, 110, 0, 0, 3, 3, 1'b1);
    cycle();
    check_out("norm_a", 1, 36, 0, 39, 0);
    check("norm_a.norm_flag", int'(norm_flag), 0);

    drive(1'b1, 20, 30, 0, 0, 0, 0, 1'b1);
    cycle();
    check_out("norm_floor", 1, 0, 0, 0, 0);

    drive(1'b1, 64, 70, 0, 0, 3, 0, 1'b1);
    cycle();
    check_out("norm_edge", 1, 0, 0, 3, 0);

    in_valid = 1'b0;
    do_start("start2");
    for (int i = 0; i < 34; i++) begin
      drive(1'b1, 1, 2, 0, 0, 0, 0, 1'b0);
      cycle();
    end
    check("depth34.tb_ready", int'(tb_ready), 0);
    cycle();
    check("depth35.tb_ready", int'(tb_ready), 1);
    cycle();
    check("depth36.tb_ready", int'(tb_ready), 1);
    in_valid = 1'b0;
    cycle();
    check("sticky.tb_ready", int'(tb_ready), 1);

    drive(1'b1, 1, 2, 0, 0, 0, 0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    in_valid = 1'b0;
    check_out("start_drop", 0, 0, 0, 32, 0);
    check("start_drop.tb_ready", int'(tb_ready), 0);
    cycle();
    check("start_drop.next_ov", int'(out_valid), 0);
    for (int i = 0; i < 34; i++) begin
      drive(1'b1, 1, 2, 0, 0, 0, 0, 1'b0);
      cycle();
    end
    check("recount34.tb_ready", int'(tb_ready), 0);
    cycle();
    check("recount35.tb_ready", int'(tb_ready), 1);

    drive(1'b1, 50, 60, 0, 0, 0, 0, 1'b0);
    cycle();
    check("pre_rst.pm_0", int'(pm_0), 50);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0);
    check("async_rst.tb_ready", int'(tb_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 10, 7, 2, 0, 0, 2, 1'b0);
    cycle();
    check_out("post_rst_idle", 0, 0, 0, 0, 0);
    do_start("start3");
    drive(1'b1, 10, 7, 2, 0, 0, 2, 1'b0);
    cycle();
    check_out("post_rst_run", 1, 7, 1, 9, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
